// File: rtl/fetch_buffer_pkg.sv
// Shared fetch/decode definitions: the IF/ID record and the default buffer depth.
package fetch_buffer_pkg;

  // Default depth used when the buffer is instantiated at the CPU top level.
  localparam int FETCH_BUF_DEPTH = 4;

  // Fetched-instruction record passed from IF to ID.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        exception_valid;
    logic [4:0]  exception_cause;
  } if_id_reg_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Enqueue/dequeue handshake bundle between fetch, the fetch buffer and decode.
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic       enq_valid;
  if_id_reg_t enq_entry;
  logic       enq_ready;
  logic       deq_valid;
  if_id_reg_t deq_entry;
  logic       deq_ready;

  // Pipeline side: fetch presents records, decode consumes them.
  modport master (
    output enq_valid, enq_entry, deq_ready,
    input  enq_ready, deq_valid, deq_entry
  );

  // Buffer side.
  modport slave (
    input  enq_valid, enq_entry, deq_ready,
    output enq_ready, deq_valid, deq_entry
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: in-order queue between IF and ID with optional empty-bypass,
// flush squash and an exception fence that blocks enqueue until the flush.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH         = FETCH_BUF_DEPTH,
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  fetch_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   fence_active
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic          r_fence;
  if_id_reg_t    r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_enq_fire;
  logic w_deq_fire;
  logic w_write;
  logic w_pop;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

  // Bypass candidate: nothing stored, so the incoming record can be the head.
  assign w_bypass = ENABLE_BYPASS && w_empty && bus.enq_valid && !r_fence;

  // enq_ready depends only on registered state and flush, never on deq_ready.
  assign bus.enq_ready = !w_full && !r_fence && !flush;
  assign bus.deq_valid = !flush && (!w_empty || w_bypass);

  // Head record from storage, else the bypassed record, else zero.
  always_comb begin
    bus.deq_entry = '0;
    if (!flush) begin
      if (!w_empty)
        bus.deq_entry = r_mem[r_head[AW-1:0]];
      else if (w_bypass)
        bus.deq_entry = bus.enq_entry;
    end
  end

  assign w_enq_fire = bus.enq_valid && bus.enq_ready;
  assign w_deq_fire = bus.deq_valid && bus.deq_ready;

  // A same-cycle enqueue+dequeue into an empty buffer is a pure pass-through.
  assign w_write = w_enq_fire && !(w_empty && w_deq_fire);
  assign w_pop   = w_deq_fire && !w_empty;

  assign count        = r_tail - r_head;
  assign fence_active = r_fence;

  // Pointer and fence state; flush squashes everything and wins over traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_fence <= 1'b0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_fence <= 1'b0;
    end else begin
      if (w_write)
        r_tail <= r_tail + PW'(1);
      if (w_pop)
        r_head <= r_head + PW'(1);
      if (w_enq_fire && bus.enq_entry.exception_valid)
        r_fence <= 1'b1;
    end
  end

  // Record storage; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_write)
      r_mem[r_tail[AW-1:0]] <= bus.enq_entry;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a bypass and a non-bypass instance share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  fetch_buffer_if bus_a ();
  fetch_buffer_if bus_b ();

  logic [CW-1:0] count_a, count_b;
  logic          fence_a, fence_b;

  fetch_buffer #(.DEPTH(DEPTH), .ENABLE_BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a.slave),
    .count(count_a), .fence_active(fence_a)
  );

  fetch_buffer #(.DEPTH(DEPTH), .ENABLE_BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b.slave),
    .count(count_b), .fence_active(fence_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: queued records and fence flag per instance.
  if_id_reg_t qa[$];
  if_id_reg_t qb[$];
  bit         fa = 1'b0;
  bit         fb = 1'b0;
  logic       er_a, dv_a, er_b, dv_b;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic if_id_reg_t mk_entry(input logic [31:0] pc, input logic exc, input logic [4:0] cause);
    if_id_reg_t e;
    e.valid           = 1'b1;
    e.pc              = pc;
    e.inst            = $urandom;
    e.pred_taken      = 1'($urandom_range(0, 1));
    e.pred_target     = $urandom;
    e.exception_valid = exc;
    e.exception_cause = cause;
    return e;
  endfunction

  // Expected dequeue/enqueue side from the queue occupancy and fence flag.
  function automatic void expect_side(input bit byp, input int sz, input bit fen, input if_id_reg_t hd,
                                      input logic v, input if_id_reg_t e, input logic f,
                                      output logic er, output logic dv, output if_id_reg_t de);
    er = (sz < DEPTH) && !fen && !f;
    dv = !f && ((sz > 0) || (byp && v && !fen));
    de = !dv ? '0 : ((sz > 0) ? hd : e);
  endfunction

  task automatic drive(input logic v, input if_id_reg_t e, input logic d, input logic f);
    bus_a.enq_valid = v;  bus_a.enq_entry = e;  bus_a.deq_ready = d;
    bus_b.enq_valid = v;  bus_b.enq_entry = e;  bus_b.deq_ready = d;
    flush = f;
  endtask

  task automatic check_all();
    if_id_reg_t hd, de;
    logic er, dv;
    hd = (qa.size() > 0) ? qa[0] : '0;
    expect_side(1'b1, qa.size(), fa, hd, bus_a.enq_valid, bus_a.enq_entry, flush, er, dv, de);
    check_val("a_enq_ready", bus_a.enq_ready, er);
    check_val("a_deq_valid", bus_a.deq_valid, dv);
    check_val("a_deq_entry", bus_a.deq_entry, de);
    check_val("a_count", count_a, qa.size());
    check_val("a_fence", fence_a, fa);
    er_a = er; dv_a = dv;
    if (dv && bus_a.deq_ready)
      $display("deq a pc=%h inst=%h exc=%0d cause=%0d count=%0d", de.pc, de.inst, de.exception_valid, de.exception_cause, qa.size());
    hd = (qb.size() > 0) ? qb[0] : '0;
    expect_side(1'b0, qb.size(), fb, hd, bus_b.enq_valid, bus_b.enq_entry, flush, er, dv, de);
    check_val("b_enq_ready", bus_b.enq_ready, er);
    check_val("b_deq_valid", bus_b.deq_valid, dv);
    check_val("b_deq_entry", bus_b.deq_entry, de);
    check_val("b_count", count_b, qb.size());
    check_val("b_fence", fence_b, fb);
    er_b = er; dv_b = dv;
  endtask

  task automatic update_models();
    bit was_empty, ea, da;
    if (flush) begin
      qa.delete(); fa = 1'b0;
      qb.delete(); fb = 1'b0;
    end else begin
      ea = bus_a.enq_valid && er_a;  da = dv_a && bus_a.deq_ready;
      was_empty = (qa.size() == 0);
      if (da && !was_empty) void'(qa.pop_front());
      if (ea && !(was_empty && da)) qa.push_back(bus_a.enq_entry);
      if (ea && bus_a.enq_entry.exception_valid) fa = 1'b1;
      ea = bus_b.enq_valid && er_b;  da = dv_b && bus_b.deq_ready;
      was_empty = (qb.size() == 0);
      if (da && !was_empty) void'(qb.pop_front());
      if (ea && !(was_empty && da)) qb.push_back(bus_b.enq_entry);
      if (ea && bus_b.enq_entry.exception_valid) fb = 1'b1;
    end
  endtask

  // One clock of traffic: drive after the edge, check mid-cycle, advance model.
  task automatic step(input logic v, input if_id_reg_t e, input logic d, input logic f);
    @(posedge clk);
    #1 drive(v, e, d, f);
    #3 check_all();
    update_models();
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; state must clear at once.
  task automatic async_reset();
    @(posedge clk);
    #2 drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    qa.delete(); qb.delete(); fa = 1'b0; fb = 1'b0;
    #1 check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic       hold_v, ev, dr, fl;
    if_id_reg_t ee;

    drive(1'b0, '0, 1'b0, 1'b0);
    #12 check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Fill to full with decode stalled, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk_entry(32'h8000_0000 + 32'(4 * i), 1'b0, 5'd0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_val("fill_count", count_a, 4);
    check_val("fill_enq_ready", bus_a.enq_ready, 1'b0);
    drain();

    // Empty-buffer bypass versus one-cycle latency without bypass.
    step(1'b1, mk_entry(32'h8000_0100, 1'b0, 5'd0), 1'b1, 1'b0);
    check_val("byp_pc", bus_a.deq_entry.pc, 32'h8000_0100);
    check_val("byp_count", count_a, 0);
    check_val("nobyp_valid", bus_b.deq_valid, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("nobyp_pc", bus_b.deq_entry.pc, 32'h8000_0100);
    drain();

    // Steady concurrent traffic at count 2, wrapping the pointers.
    for (int i = 0; i < 2; i++)
      step(1'b1, mk_entry(32'h8000_0200 + 32'(4 * i), 1'b0, 5'd0), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, mk_entry(32'h8000_0300 + 32'(4 * i), 1'b0, 5'd0), 1'b1, 1'b0);
    check_val("wrap_count", count_a, 2);
    drain();

    // Full buffer rejects enqueue even while dequeuing.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk_entry(32'h8000_0400 + 32'(4 * i), 1'b0, 5'd0), 1'b0, 1'b0);
    step(1'b1, mk_entry(32'h8000_0500, 1'b0, 5'd0), 1'b1, 1'b0);
    check_val("full_deq_enq_ready", bus_a.enq_ready, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_val("full_deq_count", count_a, 3);
    drain();

    // Flush with concurrent enqueue/dequeue squashes everything.
    for (int i = 0; i < 3; i++)
      step(1'b1, mk_entry(32'h8000_0600 + 32'(4 * i), 1'b0, 5'd0), 1'b0, 1'b0);
    step(1'b1, mk_entry(32'h8000_0700, 1'b0, 5'd0), 1'b1, 1'b1);
    check_val("flush_deq_valid", bus_a.deq_valid, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_val("post_flush_count", count_a, 0);
    check_val("post_flush_enq_ready", bus_a.enq_ready, 1'b1);

    // Exception fence: blocks enqueue, drains the faulting record, clears on flush.
    step(1'b1, mk_entry(32'h0000_1000, 1'b1, 5'd12), 1'b0, 1'b0);
    step(1'b1, mk_entry(32'h0000_1004, 1'b0, 5'd0), 1'b0, 1'b0);
    check_val("fence_set", fence_a, 1'b1);
    check_val("fence_enq_ready", bus_a.enq_ready, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("fence_drain_pc", bus_a.deq_entry.pc, 32'h0000_1000);
    check_val("fence_drain_cause", bus_a.deq_entry.exception_cause, 5'd12);
    step(1'b0, '0, 1'b0, 1'b0);
    check_val("fence_hold", fence_a, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, mk_entry(32'h0000_2000, 1'b0, 5'd0), 1'b0, 1'b0);
    check_val("fence_clear", fence_a, 1'b0);
    check_val("fence_resume", bus_a.enq_ready, 1'b1);
    drain();

    // Randomized traffic with a held enqueue record and a mid-run reset.
    hold_v = 1'b0;
    ee = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc == 500) begin
        async_reset();
        hold_v = 1'b0;
      end
      if (!hold_v) begin
        ev = ($urandom_range(0, 2) != 0);
        ee = mk_entry($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)));
      end else begin
        ev = 1'b1;
      end
      dr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      step(ev, ev ? ee : '0, dr, fl);
      hold_v = ev && !er_a && !fl;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
